// File: rtl/cpu_tx_fifo.sv
// cpu_tx_fifo: committed-packet FIFO carrying CPU words to the host-output selector.
//   clk_i       single clock (shared with the selector)
//   reset       synchronous active-high reset
//   wr_i/wdata_i  append a word to the open packet
//   commit_i    publish the open packet; abort_i discards it (abort wins)
//   re_i        read strobe; data_o is registered, valid one edge after re_i
//   empty_o     no committed unread words
//   wc_o        running count of committed words, mod 256
//   free_o      DEPTH minus all stored words; full_o when zero
//   drop_o      one-cycle pulse when an overflowed packet is discarded at commit
//   overflow_o / underflow_o  sticky error flags, cleared only by reset
module cpu_tx_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 7
) (
    input  logic                  clk_i,
    input  logic                  reset,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  commit_i,
    input  logic                  abort_i,
    input  logic                  re_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  empty_o,
    output logic [7:0]            wc_o,
    output logic [ADDR_W:0]       free_o,
    output logic                  full_o,
    output logic                  drop_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]       wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d;
    logic [ADDR_W:0]       plen_q, plen_d, wptr_w, plen_w, used;
    logic [7:0]            wc_q, wc_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  bad_q, bad_d, drop_q, drop_d, ovf_q, ovf_d, unf_q, unf_d;
    logic                  wr_ok, wr_bad, rd_ok, bad_w, drop_pkt, keep;

    // Status is derived from registered pointers, so it reflects the previous edge.
    assign used        = wptr_q - rptr_q;
    assign free_o      = DEPTH_P - used;
    assign full_o      = (used == DEPTH_P);
    assign empty_o     = (cptr_q == rptr_q);
    assign wc_o        = wc_q;
    assign data_o      = data_q;
    assign drop_o      = drop_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

    always_comb begin
        wr_ok    = wr_i && !full_o;
        wr_bad   = wr_i && full_o;
        rd_ok    = re_i && !empty_o;
        // The same-cycle write counts toward the packet being committed.
        wptr_w   = wptr_q + {{ADDR_W{1'b0}}, wr_ok};
        plen_w   = plen_q + {{ADDR_W{1'b0}}, wr_ok};
        bad_w    = bad_q | wr_bad;
        drop_pkt = commit_i && !abort_i && bad_w;
        keep     = commit_i && !abort_i && !bad_w;
        wptr_d   = (abort_i || drop_pkt) ? cptr_q : wptr_w;
        cptr_d   = keep ? wptr_w : cptr_q;
        plen_d   = (abort_i || commit_i) ? '0 : plen_w;
        bad_d    = (abort_i || commit_i) ? 1'b0 : bad_w;
        wc_d     = keep ? wc_q + 8'(plen_w) : wc_q;
        rptr_d   = rptr_q + {{ADDR_W{1'b0}}, rd_ok};
        data_d   = rd_ok ? mem_q[rptr_q[ADDR_W-1:0]] : data_q;
        drop_d   = drop_pkt;
        ovf_d    = ovf_q | wr_bad;
        unf_d    = unf_q | (re_i && empty_o);
    end

    // Reads only touch committed slots and writes never land on them, so no bypass is needed.
    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wptr_q[ADDR_W-1:0]] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            wptr_q <= '0;
            cptr_q <= '0;
            rptr_q <= '0;
            plen_q <= '0;
            wc_q   <= '0;
            data_q <= '0;
            bad_q  <= 1'b0;
            drop_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            cptr_q <= cptr_d;
            rptr_q <= rptr_d;
            plen_q <= plen_d;
            wc_q   <= wc_d;
            data_q <= data_d;
            bad_q  <= bad_d;
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end
endmodule

// File: doc/cpu_tx_fifo.md
# cpu_tx_fifo

Committed-packet FIFO carrying CPU-generated 32-bit words to the host-output selector. The CPU writes a message word by word and then commits or aborts it. Committed words become visible on the read side, and the 8-bit committed-word counter `wc_o` advances by the packet length. The selector detects pending CPU data by comparing `wc_o` against its own consumed count, then drains exactly that many words. The block sits directly upstream of the selector's CPU input.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width; matches the FTDI data bus.
- `ADDR_W`, 7, log2 of depth. DEPTH = 2^ADDR_W; ADDR_W ≤ 7 so outstanding committed words never exceed 255.

Ports:
- `clk_i`  in  1  single clock; the selector's `cpu_clk_o` is this same clock.
- `reset`  in  1  synchronous, active-high reset.
- `wr_i`  in  1  write strobe; `wdata_i` is appended to the open packet.
- `wdata_i`  in  DATA_WIDTH  write data.
- `commit_i`  in  1  close the open packet and make it readable.
- `abort_i`  in  1  discard the open (uncommitted) packet.
- `re_i`  in  1  read strobe from the selector.
- `data_o`  out  DATA_WIDTH  registered read data.
- `empty_o`  out  1  no committed unread words.
- `wc_o`  out  8  running count of committed words, mod 256.
- `free_o`  out  ADDR_W+1  free entries (DEPTH minus all stored words, committed or not).
- `full_o`  out  1  `free_o` == 0.
- `drop_o`  out  1  one-cycle pulse when a packet is discarded because of overflow.
- `overflow_o`  out  1  sticky; set by a write while full; cleared only by reset.
- `underflow_o`  out  1  sticky; set by `re_i` while `empty_o`; cleared only by reset.

## Operation
- Storage: DEPTH x DATA_WIDTH RAM plus three (ADDR_W+1)-bit pointers:
  - `wptr` marks the open packet's write position.
  - `cptr` marks the committed boundary.
  - `rptr` marks the read position.
  - All pointers wrap naturally; the MSB distinguishes full from empty.
- Stored count = `wptr`−`rptr`. `free_o` = DEPTH − (`wptr`−`rptr`). `empty_o` = (`cptr`==`rptr`).
- Write:
  - If `wr_i` is high and not full, write RAM[`wptr`] and increment `wptr` and `plen` (the open-packet length, ADDR_W+1 bits).
  - If `wr_i` is high and full, drop the word, set `overflow_o`, and set the internal `bad` flag.
- Commit (`commit_i`, no abort):
  - If `bad` is clear: `cptr`←`wptr`, `wc_o`←`wc_o`+`plen` (8-bit, wraps), `plen`←0.
  - If `bad` is set: behave as abort and pulse `drop_o`.
  - Committing with `plen`==0 is a no-op (`wc_o` unchanged).
- Abort: `wptr`←`cptr`, `plen`←0, `bad`←0. No change to `wc_o`.
- Simultaneous events:
  - `wr_i` with `commit_i`: the word is part of the committed packet, and `wc_o` includes it.
  - `wr_i` with `abort_i`: the word is discarded.
  - `commit_i` with `abort_i`: abort wins.
  - A full-drop write together with `commit_i`: the packet is dropped.
- Read: if `re_i` and not empty, `data_o`←RAM[`rptr`] and `rptr` increments. If `re_i` while empty, `data_o` holds, `rptr` is unchanged, and `underflow_o` is set.
- Read and write/commit in the same cycle are independent. A word committed in cycle N is readable from cycle N+1.
- Selector contract: it reads exactly `wc_o`−consumed words after seeing a difference. Commits during a drain only raise `wc_o` further; they never retract.

## Timing
- Reset values: `data_o`=0, `empty_o`=1, `wc_o`=0, `free_o`=DEPTH, `full_o`=0, `drop_o`=0, `overflow_o`=0, `underflow_o`=0. All pointers, `plen` and `bad` are 0.
- Reset mid-packet discards everything, committed or not.
- Read latency is 1: `re_i` sampled high at edge N gives `data_o` valid after edge N. There is no first-word fall-through. This matches the selector's one-cycle dummy state.
- `empty_o`, `full_o`, `free_o` and `wc_o` are registered and reflect all events of the previous edge.
- Commit-to-visibility:
  - `wc_o` and `empty_o` update one edge after `commit_i` is sampled.
  - `drop_o` is high for exactly the cycle after the dropping commit.
- Back-to-back reads at full rate are supported with no bubbles, including across the RAM/pointer wrap.

## Test plan
- Basic packet: write 0x11,0x22,0x33 then commit → `wc_o` 0→3 next cycle, `empty_o` 1→0. Three back-to-back `re_i` → `data_o` = 0x11,0x22,0x33 on successive cycles, then `empty_o`=1.
- Visibility and abort: write 5 words without committing → `empty_o` stays 1 and `free_o`=DEPTH−5. Assert abort → `free_o`=DEPTH and `wc_o` unchanged. A following write 0xAA + commit → `wc_o`+=1 and a read returns 0xAA.
- Overflow drop: with DEPTH=128, write 130 words then commit → `overflow_o`=1, `drop_o` pulses once, `wc_o` unchanged, `empty_o`=1, `free_o`=128.
- `wc_o` wrap: commit two 128-word packets (drained in between) → `wc_o`=0x00 after the second. Commit 3 more → `wc_o`=0x03. All read data are correct across the pointer wrap.
- Simultaneous events:
  - `wr_i`+`commit_i` in one cycle with `plen`=2 → `wc_o`+=3.
  - `wr_i`+`commit_i`+`abort_i` → `wc_o` unchanged and `free_o` restored.
  - Read of the last word concurrent with a new commit → `empty_o` stays 0.
- Underflow and reset: `re_i` while empty → `underflow_o`=1, `data_o` holds. Then assert `reset` mid-packet with committed data → all outputs return to reset values on the next edge.
